// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, through a
// single borrow flip-flop. Results and flags are held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_d_sh;
  logic             r_bin;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;

  logic w_x;
  logic w_y;
  logic w_d;
  logic w_bin_next;
  logic w_last;
  logic w_accept;

  // One-bit full-subtractor slice on the current LSBs.
  assign w_x        = r_a_sh[0];
  assign w_y        = r_b_sh[0];
  assign w_d        = w_x ^ w_y ^ r_bin;
  assign w_bin_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_bin);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_accept   = start && (r_state != RUN);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_d_sh   <= '0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a_sh  <= a;
        r_b_sh  <= b;
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
        r_bin   <= 1'b0;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a_sh <= r_a_sh >> 1;
        r_b_sh <= r_b_sh >> 1;
        r_d_sh <= {w_d, r_d_sh[WIDTH-1:1]};
        r_bin  <= w_bin_next;
        r_cnt  <= r_cnt + 1'b1;
      end
      // Final bit: publish the full result together with both flags.
      if (r_state == RUN && w_last) begin
        r_diff   <= {w_d, r_d_sh[WIDTH-1:1]};
        r_borrow <= w_bin_next;
        r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
      end
    end
  end

  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks of the 8-bit subtractor plus an exhaustive sweep of a 4-bit instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, bo8, ov8;
  logic [7:0] d8;
  logic       s4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4, done4, bo4, ov4;
  logic [3:0] d4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(d8), .borrow_out(bo8), .overflow(ov8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(s4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(d4), .borrow_out(bo4), .overflow(ov4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive start so edge E0 samples it; returns #1 after E0 with start low.
  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    s8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1;
    s8 = 1'b0;
  endtask

  // Counts edges until done is seen (bounded); checks busy on the way.
  task automatic wait_done8(input string tag, input int exp_n);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!done8 && busy8 !== 1'b1) chk({tag, "_busy"}, {31'b0, busy8}, 32'd1);
    end while (!done8 && n < 30);
    chk({tag, "_latency"}, n, exp_n);
    chk({tag, "_done_busy"}, {30'b0, done8, busy8}, 32'b10);
  endtask

  task automatic res8(input string tag, input logic [7:0] d, input logic bo, input logic ov);
    chk({tag, "_diff"}, {24'b0, d8}, {24'b0, d});
    chk({tag, "_borrow"}, {31'b0, bo8}, {31'b0, bo});
    chk({tag, "_ovf"}, {31'b0, ov8}, {31'b0, ov});
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] d, input logic bo, input logic ov);
    start8(a, b);
    wait_done8(tag, 8);
    res8(tag, d, bo, ov);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, {30'b0, done8, busy8}, 32'b00);
    $display("op %s: a=%02h b=%02h diff=%02h borrow=%0b ovf=%0b", tag, a, b, d8, bo8, ov8);
  endtask

  initial begin
    int sa, sb, r, n;
    logic exp_ov;
    repeat (3) @(posedge clk);
    #1;
    chk("rst8_flags", {29'b0, busy8, done8, bo8, ov8}, 32'd0);
    chk("rst8_diff", {24'b0, d8}, 32'd0);
    chk("rst4_all", {25'b0, busy4, done4, bo4, ov4, 3'b0} | {28'b0, d4}, 32'd0);
    reset = 1'b0;

    op8("t1", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    op8("t2", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    op8("t3", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op8("t4", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    op8("t5", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    res8("hold", 8'h80, 1'b1, 1'b1);
    chk("hold_flags", {30'b0, done8, busy8}, 32'd0);

    // start pulsed mid-run must be ignored
    start8(8'h10, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    s8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
    @(posedge clk); #1;
    s8 = 1'b0;
    chk("ign_busy", {31'b0, busy8}, 32'd1);
    wait_done8("ign", 5);
    res8("ign", 8'h0F, 1'b0, 1'b0);
    $display("op ign: diff=%02h", d8);
    // back-to-back start in the DONE cycle
    s8 = 1'b1; a8 = 8'h09; b8 = 8'h04;
    @(posedge clk); #1;
    s8 = 1'b0;
    chk("b2b_restart", {30'b0, done8, busy8}, 32'b01);
    wait_done8("b2b", 8);
    res8("b2b", 8'h05, 1'b0, 1'b0);
    $display("op b2b: diff=%02h", d8);
    @(posedge clk); #1;

    // reset during RUN aborts with no done
    start8(8'h40, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_flags", {29'b0, busy8, done8, bo8, ov8}, 32'd0);
    chk("abort_diff", {24'b0, d8}, 32'd0);
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done8) n++;
    end
    chk("abort_no_done", n, 0);
    $display("op abort: diff=%02h done_count=%0d", d8, n);
    op8("t6", 8'h22, 8'h11, 8'h11, 1'b0, 1'b0);

    // exhaustive 4-bit sweep
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        @(negedge clk);
        s4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi);
        @(posedge clk); #1;
        s4 = 1'b0;
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!done4 && n < 20);
        sa = (ai >= 8) ? ai - 16 : ai;
        sb = (bi >= 8) ? bi - 16 : bi;
        r = sa - sb;
        exp_ov = (r < -8) || (r > 7);
        chk("w4_latency", n, 4);
        chk("w4_diff", {28'b0, d4}, 32'((ai - bi) & 15));
        chk("w4_borrow", {31'b0, bo4}, {31'b0, ai < bi});
        chk("w4_ovf", {31'b0, ov4}, {31'b0, exp_ov});
        $display("w4 a=%0h b=%0h diff=%0h borrow=%0b ovf=%0b", ai, bi, d4, bo4, ov4);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
